// File: rtl/program_sequencer.sv
// program_sequencer: feeds a stored program of 9-bit words to the simple processor
// over DIN/Run, one instruction at a time, with a watchdog on the Done handshake.
module program_sequencer #(
  parameter int AW             = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_wdata,
  input  logic          Done,
  output logic [8:0]    DIN,
  output logic          Run,
  output logic          busy,
  output logic          finished,
  output logic          timeout_err,
  output logic [AW-1:0] pc,
  output logic [7:0]    instr_count
);
  localparam int              DEPTH   = 1 << AW;
  localparam int              WDW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      OP_MVI  = 3'b001;
  localparam logic [AW-1:0]   ADDR0   = '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_END} state_t;

  logic [8:0]     r_mem [DEPTH];
  state_t         r_state;
  logic [8:0]     r_din;
  logic           r_run;
  logic           r_busy;
  logic           r_finished;
  logic           r_terr;
  logic [AW-1:0]  r_pc;
  logic [7:0]     r_count;
  logic [AW:0]    r_len;
  logic           r_mvi;
  logic [WDW-1:0] r_wdog;

  logic [AW-1:0]  w_pc_plus1;
  logic [AW:0]    w_next_pc;
  logic [8:0]     w_next_word;
  logic [8:0]     w_imm;
  logic           w_cur_is_mvi;
  logic           w_prog_done;
  logic [7:0]     w_count_inc;

  assign w_pc_plus1   = r_pc + 1'b1;
  // One extra bit so the end-of-program compare sees pc+2 past the last address.
  assign w_next_pc    = {1'b0, r_pc} + (r_mvi ? (AW+1)'(2) : (AW+1)'(1));
  assign w_next_word  = r_mem[w_next_pc[AW-1:0]];
  assign w_imm        = r_mem[w_pc_plus1];
  assign w_cur_is_mvi = (r_mem[r_pc][8:6] == OP_MVI);
  assign w_prog_done  = (w_next_pc >= r_len);
  assign w_count_inc  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  // Program memory is not reset so a loaded program survives Resetn.
  always_ff @(posedge Clock) begin
    if (prog_we && !r_busy) begin
      r_mem[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_IDLE;
      r_din      <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_terr     <= 1'b0;
      r_pc       <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_mvi      <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_run      <= 1'b0;
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (prog_len != '0) begin
              r_len   <= prog_len;
              r_pc    <= '0;
              r_count <= '0;
              r_terr  <= 1'b0;
              r_busy  <= 1'b1;
              r_din   <= r_mem[ADDR0];
              r_run   <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_finished <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // mvi keeps its immediate on DIN for the whole wait.
          r_mvi   <= w_cur_is_mvi;
          r_din   <= w_cur_is_mvi ? w_imm : 9'd0;
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            r_pc    <= w_next_pc[AW-1:0];
            r_count <= w_count_inc;
            if (w_prog_done) begin
              r_busy     <= 1'b0;
              r_finished <= 1'b1;
              r_din      <= '0;
              r_state    <= S_END;
            end else begin
              r_din   <= w_next_word;
              r_run   <= 1'b1;
              r_state <= S_ISSUE;
            end
          end else if (r_wdog == WD_LAST) begin
            r_terr  <= 1'b1;
            r_busy  <= 1'b0;
            r_din   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_END: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign DIN         = r_din;
  assign Run         = r_run;
  assign busy        = r_busy;
  assign finished    = r_finished;
  assign timeout_err = r_terr;
  assign pc          = r_pc;
  assign instr_count = r_count;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Upstream feeder for the simple processor top. Holds a small loadable program memory of 9-bit instruction and immediate words.
- On start, it issues each instruction to the processor over DIN/Run and holds the immediate for mvi. It waits for Done before advancing.
- It also watches for a hung processor with a watchdog, and reports completion or timeout to the test/system level.

Parameters:
- AW, 4, program address width; memory depth = 2**AW words of 9 bits.
- TIMEOUT_CYCLES, 8, maximum WAIT cycles without Done before timeout_err; must be ≥ 2.

Ports:
- Clock  input  1  single system clock; rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- start  input  1  begin executing from address 0; sampled in IDLE only.
- prog_len  input  AW+1  number of memory words in the program; latched on accepted start.
- prog_we  input  1  memory write enable; honoured only when busy=0.
- prog_addr  input  AW  memory write address.
- prog_wdata  input  9  memory write data.
- Done  input  1  processor instruction-complete strobe.
- DIN  output  9  instruction/immediate word to processor.
- Run  output  1  one-cycle instruction-issue strobe to processor.
- busy  output  1  high from accepted start until finish or timeout.
- finished  output  1  one-cycle pulse when the program completes normally.
- timeout_err  output  1  sticky watchdog flag.
- pc  output  AW  address of current or next instruction.
- instr_count  output  8  instructions completed since last start; saturates at 255.

Behaviour:
- Reset (async, Resetn=0): state=IDLE; DIN=0, Run=0, busy=0, finished=0, timeout_err=0, pc=0, instr_count=0. Memory contents are not cleared and survive reset.
- All outputs are registered. Memory writes are synchronous; the read is asynchronous on pc / pc+1.
- Instruction format on DIN: [8:6] opcode, [5:3] X, [2:0] Y. Opcode 3'b001 (mvi) takes the following memory word as its immediate. Other opcodes are single-word.
- Processor protocol:
  - The processor captures DIN on the edge where Run=1.
  - For mvi, DIN must carry the immediate from the next cycle until Done is sampled.
  - Done may arrive as early as the first cycle after Run.
- States: IDLE, ISSUE, WAIT, END.
- IDLE:
  - start=1 and prog_len≠0: latch len, pc←0, instr_count←0, timeout_err←0, busy←1, go to ISSUE.
  - start=1 and prog_len=0: finished pulses next cycle; remain IDLE; busy stays 0.
  - Done is ignored.
- ISSUE (exactly 1 cycle): DIN=mem[pc], Run=1. Go to WAIT unconditionally. Done sampled in ISSUE is ignored.
- WAIT:
  - Run=0. DIN=mem[(pc+1) mod 2**AW] if the issued opcode is 001, else DIN=0.
  - Watchdog counter starts at 0 on entry and increments each WAIT cycle.
  - On Done=1:
    - pc advances by 2 for mvi, else by 1 (mod 2**AW on the AW-bit pc; the compare uses an AW+1-bit next-pc).
    - instr_count increments.
    - If next-pc ≥ len, go to END; else go to ISSUE. Back-to-back issue gives a 1-cycle gap minimum.
  - If the counter reaches TIMEOUT_CYCLES without Done: timeout_err←1, busy←0, DIN←0, go to IDLE (no finished pulse).
  - If Done and the timeout coincide in the same cycle, Done wins.
- END (1 cycle): finished=1, busy=0, DIN=0, then IDLE. pc holds its final value.
- mvi as the last word (pc = len-1): the immediate is read from mem[pc+1] (wrapping) and the program completes after Done.
- prog_we while busy=1 is dropped; the memory is unchanged.
- start while busy=1 is ignored.
- Resetn asserted mid-program: immediate return to the reset values above; Run is never left high.

Test Plan:
- Load mem[0]=9'h040 (mvi R0), mem[1]=9'd5, mem[2]=9'h008 (mv R1,R0), mem[3]=9'h081 (add R0,R1); prog_len=4; start; processor model Done after 3/1/2 cycles.
  -> Run pulses exactly 3 times. DIN=9'h040 on Run #1, then 9'd5 held until Done. finished pulses once; instr_count=3; pc=4; timeout_err=0.
- Same program, Done asserted in the cycle right after each Run.
  -> Each ISSUE is followed 2 cycles later by the next ISSUE. The sequence completes 6 cycles after the first Run.
- Program mem[0]=9'h008, len=1; processor never asserts Done.
  -> After 8 WAIT cycles timeout_err=1, busy=0, finished stays 0. A subsequent start clears timeout_err.
- start with prog_len=0 -> finished pulses once one cycle later; Run never asserts; busy stays 0.
- Mid-WAIT: assert prog_we (addr 0, data 9'h1FF) and start.
  -> Both are ignored; mem[0] reads back unchanged after completion; only one finished pulse.
- Pull Resetn low during WAIT of the 2nd instruction.
  -> Run=0, DIN=0, busy=0, pc=0 immediately. A restart re-executes from address 0 using the retained memory.
